// File: rtl/ssd_scan_driver_if.sv
// Bus between the value source and the seven-segment scan driver:
// display value/strobe/options in, anode/cathode drive and frame pulse out.
interface ssd_scan_driver_if;
    logic [31:0] value;
    logic        load;
    logic [7:0]  dp_in;
    logic        lz_blank;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    modport master (
        output value, load, dp_in, lz_blank,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  value, load, dp_in, lz_blank,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed 8-digit common-anode seven-segment driver with tear-free
// frame-boundary value transfer, anti-ghost blanking and leading-zero blanking.
module ssd_scan_driver #(
    parameter int unsigned DIV       = 100000,
    parameter int unsigned BLANK_CYC = 2000
) (
    input logic         clk,
    input logic         rst,
    ssd_scan_driver_if.slave bus
);
    localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [0:0] BLANK = 1'b0;
    localparam logic [0:0] SHOW  = 1'b1;

    // Hex segment decode, active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] order(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [PW-1:0] p;
    logic [2:0]    d;
    logic [31:0]   pend;
    logic          pend_v;
    logic [31:0]   active;
    logic [7:0]    active_dp;

    logic [0:0]    phase;
    logic          slot_end;
    logic          frame_end;
    logic [3:0]    nib;
    logic          suppress;
    logic [7:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;

    always_comb begin
        slot_end  = (p == PW'(DIV - 1));
        frame_end = slot_end && (d == 3'd7);
        phase     = (p < PW'(BLANK_CYC)) ? BLANK : SHOW;
        nib       = active[{d, 2'b00} +: 4];
        // Digit d is a leading zero when it and every higher nibble are zero
        suppress  = bus.lz_blank && (d != 3'd0) && ((active >> {d, 2'b00}) == '0);

        an_next  = '1;
        seg_next = '1;
        dp_next  = 1'b1;
        if (phase == SHOW) begin
            an_next[d] = 1'b0;
            if (!suppress) begin
                seg_next = order(nib);
                dp_next  = ~active_dp[d];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p      <= '0;
            d      <= '0;
            pend   <= '0;
            pend_v <= 1'b0;
            active <= '0;
            active_dp <= '0;
        end else begin
            if (slot_end) begin
                p <= '0;
                d <= d + 3'd1;
            end else begin
                p <= p + PW'(1);
            end

            if (bus.load) begin
                pend   <= bus.value;
                pend_v <= 1'b1;
            end

            // A load in the boundary cycle bypasses pend and wins over it
            if (frame_end) begin
                active_dp <= bus.dp_in;
                if (bus.load) begin
                    active <= bus.value;
                    pend_v <= 1'b0;
                end else if (pend_v) begin
                    active <= pend;
                    pend_v <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.an         <= '1;
            bus.seg        <= '1;
            bus.dp         <= 1'b1;
            bus.frame_done <= 1'b0;
        end else begin
            bus.an         <= an_next;
            bus.seg        <= seg_next;
            bus.dp         <= dp_next;
            bus.frame_done <= frame_end;
        end
    end
endmodule
